// File: rtl/mips_int_ctrl.sv
// mips_int_ctrl
//   Vectored interrupt controller for the single-cycle MIPS core. It arbitrates
//   level-sensitive device requests and redirects the PC to a per-source vector.
//   It captures the return address in EPC and owns the global interrupt enable
//   and the per-source mask. It also sequences enter / service / return (JEPC).
//
//   Optional build macro: INT_RR_PRIORITY_EN
//     defined   -> rotating priority. The search starts at the RR pointer and
//                  wraps upward. The pointer moves to (granted id + 1).
//     undefined -> fixed priority. The lowest index wins and there is no
//                  pointer register.
//
// Ports
//   clk          in   clock
//   reset        in   asynchronous, active-high reset
//   irq          in   [NUM_IRQ] level requests, held by the device until acked
//   pc_next_in   in   [32] datapath next-PC before redirect
//   eret         in   JEPC decoded this cycle
//   ie_we/ie_wd  in   global interrupt-enable write strobe / data
//   mask_we      in   mask write strobe
//   mask_wd      in   [NUM_IRQ] mask data, 1 = source enabled
//   take_int     out  PC mux selects vector_addr this cycle
//   vector_addr  out  [32] VEC_BASE + (irq_id << VEC_STRIDE_LOG2)
//   int_ack      out  [NUM_IRQ] one-hot acknowledge, high only in TAKE
//   epc          out  [32] exception PC (JEPC target)
//   ie           out  global interrupt enable
//   in_service   out  high while a handler runs
//   irq_id       out  [clog2(NUM_IRQ)] id of the last granted source
//
// State table
//   state      | meaning
//   IDLE       | waiting for an enabled, unmasked request
//   TAKE       | one-cycle redirect to the vector, ack to the device
//   SERVICE    | handler running, no nesting, leave on eret

module mips_int_ctrl #(
    parameter int unsigned NUM_IRQ         = 4,
    parameter logic [31:0] VEC_BASE        = 32'h0000_0100,
    parameter int unsigned VEC_STRIDE_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_IRQ-1:0]         irq,
    input  logic [31:0]                pc_next_in,
    input  logic                       eret,
    input  logic                       ie_we,
    input  logic                       ie_wd,
    input  logic                       mask_we,
    input  logic [NUM_IRQ-1:0]         mask_wd,
    output logic                       take_int,
    output logic [31:0]                vector_addr,
    output logic [NUM_IRQ-1:0]         int_ack,
    output logic [31:0]                epc,
    output logic                       ie,
    output logic                       in_service,
    output logic [$clog2(NUM_IRQ)-1:0] irq_id
);

    localparam int ID_W = $clog2(NUM_IRQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] pending;
    logic [ID_W-1:0]    winner;
    logic               found;

    assign pending = irq & mask;

`ifdef INT_RR_PRIORITY_EN
    logic [ID_W-1:0]      rr_ptr;
    logic [2*NUM_IRQ-1:0] pend_rot;
    int                   sum;

    // Rotate the pending vector so that bit 0 is the source at the pointer.
    // The first set bit then gives the offset from the pointer, and the
    // winner is that offset added back modulo NUM_IRQ.
    always_comb begin
        pend_rot = {pending, pending} >> rr_ptr;
        winner   = '0;
        found    = 1'b0;
        sum      = 0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (!found && pend_rot[i]) begin
                found = 1'b1;
                sum   = int'(rr_ptr) + i;
                if (sum >= int'(NUM_IRQ)) begin
                    sum = sum - int'(NUM_IRQ);
                end
                winner = ID_W'(sum);
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (!found && pending[i]) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
    end
`endif

    assign vector_addr = VEC_BASE + (32'(irq_id) << VEC_STRIDE_LOG2);

    // take_int, int_ack and in_service are registered at the same edge that
    // enters the corresponding state, so they exactly track the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ie         <= 1'b0;
            mask       <= '0;
            epc        <= '0;
            irq_id     <= '0;
            take_int   <= 1'b0;
            int_ack    <= '0;
            in_service <= 1'b0;
`ifdef INT_RR_PRIORITY_EN
            rr_ptr     <= '0;
`endif
        end else begin
            if (mask_we) begin
                mask <= mask_wd;
            end

            case (state)
                ST_IDLE: begin
                    if (ie_we) begin
                        ie <= ie_wd;
                    end
                    // The arbitration uses the registered ie and mask, so a
                    // write in this cycle only affects the next decision.
                    if (ie && (pending != '0)) begin
                        state    <= ST_TAKE;
                        irq_id   <= winner;
                        take_int <= 1'b1;
                        int_ack  <= {{(NUM_IRQ-1){1'b0}}, 1'b1} << winner;
`ifdef INT_RR_PRIORITY_EN
                        if (winner == ID_W'(NUM_IRQ - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= winner + 1'b1;
                        end
`endif
                    end
                end

                ST_TAKE: begin
                    // The instruction in flight completes, so the next PC it
                    // produces (including a branch target) is the return address.
                    // The hardware clear of ie overrides any software write.
                    epc        <= pc_next_in;
                    ie         <= 1'b0;
                    state      <= ST_SERVICE;
                    take_int   <= 1'b0;
                    int_ack    <= '0;
                    in_service <= 1'b1;
                end

                ST_SERVICE: begin
                    if (eret) begin
                        ie         <= 1'b1;
                        state      <= ST_IDLE;
                        in_service <= 1'b0;
                    end else if (ie_we) begin
                        ie <= ie_wd;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    take_int   <= 1'b0;
                    int_ack    <= '0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_int_ctrl.sv
module tb_mips_int_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  irq;
    logic [31:0] pc_next_in;
    logic        eret;
    logic        ie_we;
    logic        ie_wd;
    logic        mask_we;
    logic [3:0]  mask_wd;
    logic        take_int;
    logic [31:0] vector_addr;
    logic [3:0]  int_ack;
    logic [31:0] epc;
    logic        ie;
    logic        in_service;
    logic [1:0]  irq_id;

    int checks   = 0;
    int failures = 0;

    mips_int_ctrl #(
        .NUM_IRQ(4),
        .VEC_BASE(32'h0000_0100),
        .VEC_STRIDE_LOG2(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .irq(irq),
        .pc_next_in(pc_next_in),
        .eret(eret),
        .ie_we(ie_we),
        .ie_wd(ie_wd),
        .mask_we(mask_we),
        .mask_wd(mask_wd),
        .take_int(take_int),
        .vector_addr(vector_addr),
        .int_ack(int_ack),
        .epc(epc),
        .ie(ie),
        .in_service(in_service),
        .irq_id(irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        irq   = 4'b0001;
        step();
        step();
        checks++; if (take_int !== 1'b0) begin failures++; $display("FAIL rst_take got=%0b exp=0", take_int); end
        checks++; if (int_ack !== 4'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0000", int_ack); end
        checks++; if (in_service !== 1'b0) begin failures++; $display("FAIL rst_insvc got=%0b exp=0", in_service); end
        checks++; if (ie !== 1'b0) begin failures++; $display("FAIL rst_ie got=%0b exp=0", ie); end
        checks++; if (epc !== 32'h0) begin failures++; $display("FAIL rst_epc got=%h exp=0", epc); end
        checks++; if (irq_id !== 2'd0) begin failures++; $display("FAIL rst_id got=%0d exp=0", irq_id); end
        checks++; if (vector_addr !== 32'h100) begin failures++; $display("FAIL rst_vec got=%h exp=100", vector_addr); end
        reset   = 1'b0;
        mask_we = 1'b1;
        mask_wd = 4'hF;
        step();
        mask_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (take_int !== 1'b0 || int_ack !== 4'b0 || in_service !== 1'b0) begin
                failures++;
                $display("FAIL ie0_notake cyc=%0d take=%0b ack=%b insvc=%0b exp=0/0000/0", i, take_int, int_ack, in_service);
            end
        end
    endtask

    task automatic test_take();
        irq        = 4'b0100;
        pc_next_in = 32'h40;
        ie_we      = 1'b1;
        ie_wd      = 1'b1;
        step();
        ie_we = 1'b0;
        checks++; if (ie !== 1'b1 || take_int !== 1'b0) begin failures++; $display("FAIL take_pre ie=%0b take=%0b exp=1/0", ie, take_int); end
        step();
        checks++; if (take_int !== 1'b1) begin failures++; $display("FAIL take_int got=%0b exp=1", take_int); end
        checks++; if (int_ack !== 4'b0100) begin failures++; $display("FAIL take_ack got=%b exp=0100", int_ack); end
        checks++; if (vector_addr !== 32'h120) begin failures++; $display("FAIL take_vec got=%h exp=120", vector_addr); end
        checks++; if (irq_id !== 2'd2) begin failures++; $display("FAIL take_id got=%0d exp=2", irq_id); end
        step();
        checks++; if (epc !== 32'h40) begin failures++; $display("FAIL svc_epc got=%h exp=40", epc); end
        checks++; if (ie !== 1'b0) begin failures++; $display("FAIL svc_ie got=%0b exp=0", ie); end
        checks++; if (in_service !== 1'b1) begin failures++; $display("FAIL svc_insvc got=%0b exp=1", in_service); end
        checks++; if (take_int !== 1'b0 || int_ack !== 4'b0) begin failures++; $display("FAIL svc_take take=%0b ack=%b exp=0/0000", take_int, int_ack); end
        irq  = 4'b0;
        eret = 1'b1;
        step();
        eret = 1'b0;
        checks++; if (ie !== 1'b1 || in_service !== 1'b0) begin failures++; $display("FAIL eret_ret ie=%0b insvc=%0b exp=1/0", ie, in_service); end
    endtask

    task automatic test_priority();
        logic [1:0]  exp_id2;
        logic [31:0] exp_vec2;
`ifdef INT_RR_PRIORITY_EN
        exp_id2  = 2'd3;
        exp_vec2 = 32'h130;
`else
        exp_id2  = 2'd1;
        exp_vec2 = 32'h110;
`endif
        reset = 1'b1;
        step();
        reset   = 1'b0;
        irq     = 4'b0;
        mask_we = 1'b1;
        mask_wd = 4'hF;
        ie_we   = 1'b1;
        ie_wd   = 1'b1;
        step();
        mask_we = 1'b0;
        ie_we   = 1'b0;
        irq     = 4'b1010;
        step();
        checks++; if (take_int !== 1'b1 || irq_id !== 2'd1) begin failures++; $display("FAIL prio1_id take=%0b id=%0d exp=1/1", take_int, irq_id); end
        checks++; if (vector_addr !== 32'h110 || int_ack !== 4'b0010) begin failures++; $display("FAIL prio1_vec vec=%h ack=%b exp=110/0010", vector_addr, int_ack); end
        step();
        eret = 1'b1;
        step();
        eret = 1'b0;
        step();
        checks++; if (take_int !== 1'b1 || irq_id !== exp_id2) begin failures++; $display("FAIL prio2_id take=%0b id=%0d exp=1/%0d", take_int, irq_id, exp_id2); end
        checks++; if (vector_addr !== exp_vec2) begin failures++; $display("FAIL prio2_vec got=%h exp=%h", vector_addr, exp_vec2); end
        step();
        irq  = 4'b0;
        eret = 1'b1;
        step();
        eret = 1'b0;
    endtask

    task automatic test_back_to_back();
        irq        = 4'b0001;
        pc_next_in = 32'h80;
        step();
        ie_we = 1'b1;
        ie_wd = 1'b1;
        checks++; if (take_int !== 1'b1 || irq_id !== 2'd0) begin failures++; $display("FAIL b2b_take1 take=%0b id=%0d exp=1/0", take_int, irq_id); end
        step();
        ie_we = 1'b0;
        checks++; if (ie !== 1'b0 || epc !== 32'h80) begin failures++; $display("FAIL take_ieclr ie=%0b epc=%h exp=0/80", ie, epc); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (take_int !== 1'b0 || in_service !== 1'b1) begin
                failures++;
                $display("FAIL no_nest cyc=%0d take=%0b insvc=%0b exp=0/1", i, take_int, in_service);
            end
        end
        eret  = 1'b1;
        ie_we = 1'b1;
        ie_wd = 1'b0;
        step();
        eret  = 1'b0;
        ie_we = 1'b0;
        checks++; if (ie !== 1'b1 || in_service !== 1'b0 || take_int !== 1'b0) begin failures++; $display("FAIL eret_wins ie=%0b insvc=%0b take=%0b exp=1/0/0", ie, in_service, take_int); end
        step();
        checks++; if (take_int !== 1'b1 || irq_id !== 2'd0) begin failures++; $display("FAIL b2b_take2 take=%0b id=%0d exp=1/0", take_int, irq_id); end
        step();
        irq  = 4'b0;
        eret = 1'b1;
        step();
        eret  = 1'b0;
        ie_we = 1'b1;
        ie_wd = 1'b0;
        step();
        ie_we = 1'b0;
        eret  = 1'b1;
        step();
        eret = 1'b0;
        checks++; if (ie !== 1'b0 || in_service !== 1'b0 || take_int !== 1'b0 || epc !== 32'h80) begin
            failures++;
            $display("FAIL eret_idle ie=%0b insvc=%0b take=%0b epc=%h exp=0/0/0/80", ie, in_service, take_int, epc);
        end
    endtask

    task automatic test_mask();
        mask_we    = 1'b1;
        mask_wd    = 4'b1110;
        ie_we      = 1'b1;
        ie_wd      = 1'b1;
        irq        = 4'b0001;
        pc_next_in = 32'h40;
        step();
        mask_we = 1'b0;
        ie_we   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (take_int !== 1'b0) begin failures++; $display("FAIL masked cyc=%0d take=%0b exp=0", i, take_int); end
        end
        mask_we = 1'b1;
        mask_wd = 4'b0001;
        step();
        mask_we = 1'b0;
        checks++; if (take_int !== 1'b0) begin failures++; $display("FAIL mask_n1 take=%0b exp=0", take_int); end
        step();
        checks++; if (take_int !== 1'b1 || irq_id !== 2'd0 || vector_addr !== 32'h100) begin
            failures++;
            $display("FAIL mask_n2 take=%0b id=%0d vec=%h exp=1/0/100", take_int, irq_id, vector_addr);
        end
        step();
    endtask

    task automatic test_reset_mid();
        checks++; if (in_service !== 1'b1 || epc !== 32'h40) begin failures++; $display("FAIL mid_pre insvc=%0b epc=%h exp=1/40", in_service, epc); end
        reset = 1'b1;
        #1;
        checks++; if (in_service !== 1'b0 || ie !== 1'b0 || epc !== 32'h0 || take_int !== 1'b0 || irq_id !== 2'd0) begin
            failures++;
            $display("FAIL mid_rst insvc=%0b ie=%0b epc=%h take=%0b id=%0d exp=0/0/0/0/0", in_service, ie, epc, take_int, irq_id);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (take_int !== 1'b0 || in_service !== 1'b0) begin failures++; $display("FAIL mid_after cyc=%0d take=%0b insvc=%0b exp=0/0", i, take_int, in_service); end
        end
    endtask

    initial begin
        reset      = 1'b1;
        irq        = 4'b0;
        pc_next_in = 32'h0;
        eret       = 1'b0;
        ie_we      = 1'b0;
        ie_wd      = 1'b0;
        mask_we    = 1'b0;
        mask_wd    = 4'b0;
        test_reset();
        test_take();
        test_priority();
        test_back_to_back();
        test_mask();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
